// File: rtl/len5_pkg.sv
// Shared fetch-side constants, RISC-V jump opcodes and RAS operation encoding.
package len5_pkg;

    localparam int unsigned ALEN = 32;
    localparam int unsigned ILEN = 32;

    localparam logic [6:0] OPCODE_JAL  = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR = 7'b1100111;

    typedef enum logic [1:0] {
        RAS_NONE,
        RAS_PUSH,
        RAS_POP,
        RAS_PUSH_POP
    } ras_op_t;

    // x1 (ra) and x5 (t0) are the RISC-V link registers
    function automatic logic is_link(input logic [4:0] r);
        return (r == 5'd1) || (r == 5'd5);
    endfunction

endpackage

// File: rtl/ras_predecoder_call_ret_decoder.sv
// Combinational call/return classifier using the RISC-V link-register hints.
// Define LEN5_C_EXT_EN to also decode compressed C.JAL / C.JR / C.JALR.
module call_ret_decoder
    import len5_pkg::*;
#(
    parameter int unsigned ALEN = len5_pkg::ALEN,
    parameter int unsigned ILEN = len5_pkg::ILEN
) (
    input  logic [ILEN-1:0] instr,
    input  logic [ALEN-1:0] pc,
    output ras_op_t         op,
    output logic [ALEN-1:0] link_addr
);

    logic [4:0] rd;
    logic [4:0] rs1;
    logic       rd_link;
    logic       rs1_link;
    logic       unused_bits;

    assign rd          = instr[11:7];
    assign rs1         = instr[19:15];
    assign rd_link     = is_link(rd);
    assign rs1_link    = is_link(rs1);
    assign unused_bits = ^{instr[ILEN-1:20], instr[14:12]};

`ifdef LEN5_C_EXT_EN
    logic [4:0] c_rs1;
    logic [4:0] c_rs2;
    logic       c_rs1_link;

    assign c_rs1      = instr[11:7];
    assign c_rs2      = instr[6:2];
    assign c_rs1_link = is_link(c_rs1);
`endif

    always_comb begin
        op        = RAS_NONE;
        link_addr = pc + ALEN'(4);
        if (instr[6:0] == OPCODE_JAL) begin
            if (rd_link) begin
                op = RAS_PUSH;
            end
        end else if (instr[6:0] == OPCODE_JALR) begin
            unique case ({rd_link, rs1_link})
                2'b10:   op = RAS_PUSH;
                2'b01:   op = RAS_POP;
                2'b11:   op = (rd == rs1) ? RAS_PUSH : RAS_PUSH_POP;
                default: op = RAS_NONE;
            endcase
        end
`ifdef LEN5_C_EXT_EN
        // 16-bit encodings: C.JALR always links through x1
        if (instr[1:0] != 2'b11) begin
            op        = RAS_NONE;
            link_addr = pc + ALEN'(2);
            if ((instr[1:0] == 2'b10) && (instr[15:13] == 3'b100) &&
                (c_rs1 != 5'd0) && (c_rs2 == 5'd0)) begin
                if (instr[12]) begin
                    op = (c_rs1_link && (c_rs1 != 5'd1)) ? RAS_PUSH_POP : RAS_PUSH;
                end else if (c_rs1_link) begin
                    op = RAS_POP;
                end
            end else if ((instr[1:0] == 2'b01) && (instr[15:13] == 3'b001)) begin
                op = RAS_PUSH;
            end
        end
`endif
    end

endmodule

// File: rtl/ras_predecoder.sv
// Fetch pipeline register that pre-decodes calls/returns, drives the RAS and
// redirects fetch on predicted returns. Compressed decode via LEN5_C_EXT_EN.
module ras_predecoder
    import len5_pkg::*;
#(
    parameter int unsigned ALEN = len5_pkg::ALEN,
    parameter int unsigned ILEN = len5_pkg::ILEN
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            flush_i,
    input  logic            valid_i,
    output logic            ready_o,
    input  logic [ALEN-1:0] pc_i,
    input  logic [ILEN-1:0] instr_i,
    output logic            valid_o,
    input  logic            ready_i,
    output logic [ALEN-1:0] pc_o,
    output logic [ILEN-1:0] instr_o,
    output logic            pred_ret_o,
    output logic [ALEN-1:0] pred_target_o,
    output logic            ras_push_o,
    output logic            ras_pop_o,
    output logic [ALEN-1:0] ras_link_addr_o,
    input  logic            ras_valid_i,
    input  logic [ALEN-1:0] ras_ret_addr_i,
    output logic            redirect_o,
    output logic [ALEN-1:0] redirect_target_o
);

    logic            valid_q;
    logic            fresh_q;
    logic            ret_q;
    logic            init_q;
    logic [ALEN-1:0] pc_q;
    logic [ALEN-1:0] tgt_q;
    logic [ILEN-1:0] instr_q;

    ras_op_t         op;
    logic [ALEN-1:0] link_addr;
    logic            fresh;
    logic            is_call;
    logic            is_ret;
    logic            accept;
    logic            transfer;

    call_ret_decoder #(
        .ALEN (ALEN),
        .ILEN (ILEN)
    ) u_decoder (
        .instr     (instr_q),
        .pc        (pc_q),
        .op        (op),
        .link_addr (link_addr)
    );

    // RAS side effects only in the first valid cycle of an entry
    assign fresh   = valid_q && fresh_q && !flush_i;
    assign is_call = (op == RAS_PUSH) || (op == RAS_PUSH_POP);
    assign is_ret  = (op == RAS_POP)  || (op == RAS_PUSH_POP);

    assign ras_push_o        = fresh && is_call;
    assign ras_pop_o         = fresh && is_ret;
    assign ras_link_addr_o   = ras_push_o ? link_addr : '0;
    assign redirect_o        = ras_pop_o && ras_valid_i;
    assign redirect_target_o = redirect_o ? ras_ret_addr_i : '0;

    // A redirected return is held one cycle so it leaves with its prediction
    assign ready_o  = init_q && (!valid_q || ready_i) && !redirect_o;
    assign valid_o  = valid_q && !redirect_o && !flush_i;
    assign accept   = valid_i && ready_o && !flush_i;
    assign transfer = valid_o && ready_i;

    assign pc_o          = pc_q;
    assign instr_o       = instr_q;
    assign pred_ret_o    = ret_q;
    assign pred_target_o = tgt_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            init_q  <= 1'b0;
            valid_q <= 1'b0;
            fresh_q <= 1'b0;
            ret_q   <= 1'b0;
            tgt_q   <= '0;
            pc_q    <= '0;
            instr_q <= '0;
        end else begin
            init_q <= 1'b1;
            if (flush_i) begin
                valid_q <= 1'b0;
                fresh_q <= 1'b0;
                ret_q   <= 1'b0;
                tgt_q   <= '0;
            end else if (accept) begin
                valid_q <= 1'b1;
                fresh_q <= 1'b1;
                pc_q    <= pc_i;
                instr_q <= instr_i;
                ret_q   <= 1'b0;
                tgt_q   <= '0;
            end else begin
                if (transfer) begin
                    valid_q <= 1'b0;
                    ret_q   <= 1'b0;
                    tgt_q   <= '0;
                end else if (redirect_o) begin
                    ret_q <= 1'b1;
                    tgt_q <= ras_ret_addr_i;
                end
                if (valid_q) begin
                    fresh_q <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_ras_predecoder.sv
// Scoreboard bench for ras_predecoder: directed scenarios plus random traffic
// against a queue-based model of the call/return stack.
module tb_ras_predecoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush_i;
    logic        valid_i;
    logic        ready_o;
    logic [31:0] pc_i;
    logic [31:0] instr_i;
    logic        valid_o;
    logic        ready_i;
    logic [31:0] pc_o;
    logic [31:0] instr_o;
    logic        pred_ret_o;
    logic [31:0] pred_target_o;
    logic        ras_push_o;
    logic        ras_pop_o;
    logic [31:0] ras_link_addr_o;
    logic        ras_valid_i;
    logic [31:0] ras_ret_addr_i;
    logic        redirect_o;
    logic [31:0] redirect_target_o;

    always #5 clk = ~clk;

    ras_predecoder dut (
        .clk_i             (clk),
        .rst_i             (rst),
        .flush_i           (flush_i),
        .valid_i           (valid_i),
        .ready_o           (ready_o),
        .pc_i              (pc_i),
        .instr_i           (instr_i),
        .valid_o           (valid_o),
        .ready_i           (ready_i),
        .pc_o              (pc_o),
        .instr_o           (instr_o),
        .pred_ret_o        (pred_ret_o),
        .pred_target_o     (pred_target_o),
        .ras_push_o        (ras_push_o),
        .ras_pop_o         (ras_pop_o),
        .ras_link_addr_o   (ras_link_addr_o),
        .ras_valid_i       (ras_valid_i),
        .ras_ret_addr_i    (ras_ret_addr_i),
        .redirect_o        (redirect_o),
        .redirect_target_o (redirect_target_o)
    );

    typedef struct packed {
        logic        push;
        logic        pop;
        logic [31:0] link;
        logic        red;
        logic [31:0] tgt;
    } ops_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] ins;
        logic        red;
        logic [31:0] tgt;
    } xfer_t;

    ops_t        exp_ops[$];
    xfer_t       exp_xfer[$];
    logic [31:0] mstack[$];
    logic [31:0] estack[$];

    int          errors = 0;
    int          checks = 0;
    bit          mon_en = 1'b0;
    bit          pend_v = 1'b0;
    logic [31:0] pend_pc;
    logic [31:0] pend_ins;
    bit          dummy;

    function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic logic [31:0] jal(input logic [4:0] rd);
        return {20'h00010, rd, 7'h6F};
    endfunction

    function automatic logic [31:0] jalr(input logic [4:0] rd, input logic [4:0] rs1);
        return {12'h000, rs1, 3'b000, rd, 7'h67};
    endfunction

    // Reference classification straight from the link-register hint rules
    function automatic void classify(input logic [31:0] ins, output logic push, output logic pop);
        logic [4:0] rd;
        logic [4:0] rs1;
        bit rd_l;
        bit rs_l;
        rd   = ins[11:7];
        rs1  = ins[19:15];
        rd_l = (rd == 5'd1) || (rd == 5'd5);
        rs_l = (rs1 == 5'd1) || (rs1 == 5'd5);
        push = 1'b0;
        pop  = 1'b0;
        if (ins[6:0] == 7'h6F) begin
            push = rd_l;
        end else if (ins[6:0] == 7'h67) begin
            push = rd_l;
            pop  = rs_l && !(rd_l && (rd == rs1));
        end
    endfunction

    // Entry reaches its first valid cycle: predict its RAS effects and its exit
    function automatic void model_fresh(input logic [31:0] pc, input logic [31:0] ins);
        ops_t  o;
        xfer_t x;
        logic  push;
        logic  pop;
        classify(ins, push, pop);
        o.push = push;
        o.pop  = pop;
        o.link = pc + 32'd4;
        o.red  = pop && (mstack.size() > 0);
        o.tgt  = o.red ? mstack[$] : 32'h0;
        exp_ops.push_back(o);
        if (pop && (mstack.size() > 0)) void'(mstack.pop_back());
        if (push) mstack.push_back(o.link);
        x.pc  = pc;
        x.ins = ins;
        x.red = o.red;
        x.tgt = o.tgt;
        exp_xfer.push_back(x);
    endfunction

    function automatic logic [4:0] pick_reg();
        case ($urandom_range(0, 3))
            0:       return 5'd0;
            1:       return 5'd1;
            2:       return 5'd5;
            default: return 5'($urandom_range(0, 31));
        endcase
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] w;
        int k;
        w = $urandom();
        k = $urandom_range(0, 9);
        if (k < 3)      w = {w[31:12], pick_reg(), 7'h6F};
        else if (k < 8) w = {w[31:20], pick_reg(), 3'b000, pick_reg(), 7'h67};
        else            w = {w[31:12], pick_reg(), 7'h13};
        return w;
    endfunction

    task automatic step(input logic v, input logic [31:0] pc, input logic [31:0] ins,
                        input logic rdy, input logic fl, output bit acc);
        @(posedge clk);
        #1;
        if (fl) exp_xfer.delete();
        if (pend_v) begin
            pend_v = 1'b0;
            if (!fl) model_fresh(pend_pc, pend_ins);
        end
        flush_i = fl;
        valid_i = v;
        ready_i = rdy;
        pc_i    = pc;
        instr_i = ins;
        @(negedge clk);
        acc = v && ready_o && !fl;
        if (acc) begin
            pend_v   = 1'b1;
            pend_pc  = pc;
            pend_ins = ins;
        end
    endtask

    task automatic idle(input logic rdy);
        step(1'b0, 32'h0, 32'h0, rdy, 1'b0, dummy);
    endtask

    task automatic issue(input logic [31:0] pc, input logic [31:0] ins, input logic rdy);
        bit acc;
        acc = 1'b0;
        for (int i = 0; i < 20 && !acc; i++) step(1'b1, pc, ins, rdy, 1'b0, acc);
        checks++;
        if (!acc) begin
            errors++;
            $display("FAIL issue_accept: pc %h never accepted", pc);
        end
    endtask

    // RAS environment: a real stack updated from the DUT's requests
    initial begin
        logic        p;
        logic        q;
        logic [31:0] l;
        ras_valid_i    = 1'b0;
        ras_ret_addr_i = 32'h0;
        forever begin
            @(negedge clk);
            p = ras_push_o;
            q = ras_pop_o;
            l = ras_link_addr_o;
            @(posedge clk);
            #1;
            if (rst) begin
                estack.delete();
            end else begin
                if (q && (estack.size() > 0)) void'(estack.pop_back());
                if (p) estack.push_back(l);
            end
            ras_valid_i    = estack.size() > 0;
            ras_ret_addr_i = (estack.size() > 0) ? estack[$] : $urandom();
        end
    end

    // Monitor: compares RAS pulses and transfers against the scoreboard queues
    initial begin
        ops_t  e;
        xfer_t x;
        forever begin
            @(negedge clk);
            if (mon_en) begin
                if (exp_ops.size() > 0) begin
                    e = exp_ops.pop_front();
                    check("ras_push", 32'(ras_push_o), 32'(e.push));
                    check("ras_pop", 32'(ras_pop_o), 32'(e.pop));
                    check("redirect", 32'(redirect_o), 32'(e.red));
                    if (e.push) check("link_addr", ras_link_addr_o, e.link);
                    if (e.red) begin
                        check("redirect_target", redirect_target_o, e.tgt);
                        check("ready_in_redirect", 32'(ready_o), 32'h0);
                    end
                end else begin
                    check("idle_ras_ops", {29'h0, ras_push_o, ras_pop_o, redirect_o}, 32'h0);
                end
                if (valid_o) begin
                    if (exp_xfer.size() == 0) begin
                        check("unexpected_valid_o", 32'(valid_o), 32'h0);
                    end else begin
                        check("pc_o", pc_o, exp_xfer[0].pc);
                        check("instr_o", instr_o, exp_xfer[0].ins);
                        if (ready_i) begin
                            x = exp_xfer.pop_front();
                            check("pred_ret", 32'(pred_ret_o), 32'(x.red));
                            check("pred_target", pred_target_o, x.tgt);
                        end
                    end
                end
            end
        end
    end

    initial begin
        rst     = 1'b1;
        flush_i = 1'b0;
        valid_i = 1'b0;
        ready_i = 1'b0;
        pc_i    = 32'h0;
        instr_i = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_valid_o", 32'(valid_o), 32'h0);
        check("rst_ready_o", 32'(ready_o), 32'h0);
        check("rst_push", 32'(ras_push_o), 32'h0);
        check("rst_pop", 32'(ras_pop_o), 32'h0);
        check("rst_redirect", 32'(redirect_o), 32'h0);
        check("rst_pc_o", pc_o, 32'h0);
        check("rst_instr_o", instr_o, 32'h0);
        check("rst_pred_ret", 32'(pred_ret_o), 32'h0);
        check("rst_pred_target", pred_target_o, 32'h0);
        check("rst_link_addr", ras_link_addr_o, 32'h0);
        check("rst_redirect_target", redirect_target_o, 32'h0);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("ready_after_reset", 32'(ready_o), 32'h1);
        mon_en = 1'b1;

        // Call, then a return that hits the pushed link address
        issue(32'h0000_1000, jal(5'd1), 1'b1);
        issue(32'h0000_2000, jalr(5'd0, 5'd1), 1'b1);
        // Same return with an empty stack: pop without redirect
        issue(32'h0000_2000, jalr(5'd0, 5'd1), 1'b1);
        idle(1'b1);
        // Coroutine swap (push+pop) and rd == rs1 (push only)
        issue(32'h0000_3000, jal(5'd1), 1'b1);
        issue(32'h0000_3100, jalr(5'd1, 5'd5), 1'b1);
        issue(32'h0000_3200, jalr(5'd1, 5'd1), 1'b1);
        // Link address wraps silently
        issue(32'hFFFF_FFFC, jal(5'd5), 1'b1);
        repeat (3) idle(1'b1);

        // Call stalled downstream for five cycles
        issue(32'h0000_4000, jal(5'd1), 1'b0);
        repeat (5) idle(1'b0);
        idle(1'b1);

        // Flush during the fresh cycle of a call, concurrent input dropped
        issue(32'h0000_5000, jal(5'd1), 1'b1);
        step(1'b1, 32'h0000_5004, jal(5'd1), 1'b1, 1'b1, dummy);
        repeat (2) idle(1'b1);

        // Asynchronous reset in the middle of a stall
        issue(32'h0000_6000, jal(5'd1), 1'b0);
        repeat (2) idle(1'b0);
        mon_en = 1'b0;
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("arst_valid_o", 32'(valid_o), 32'h0);
        check("arst_pc_o", pc_o, 32'h0);
        check("arst_instr_o", instr_o, 32'h0);
        check("arst_ready_o", 32'(ready_o), 32'h0);
        check("arst_push", 32'(ras_push_o), 32'h0);
        exp_ops.delete();
        exp_xfer.delete();
        mstack.delete();
        pend_v = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        mon_en = 1'b1;

        // Random traffic with stalls and occasional flushes
        for (int i = 0; i < 1500; i++) begin
            logic [31:0] pc;
            pc = $urandom() & 32'hFFFF_FFFC;
            if ($urandom_range(0, 40) == 0) pc = 32'hFFFF_FFFC;
            step($urandom_range(0, 3) != 0, pc, rand_instr(), $urandom_range(0, 3) != 0,
                 $urandom_range(0, 40) == 0, dummy);
        end

        for (int i = 0; i < 10 && (exp_xfer.size() > 0 || pend_v); i++) idle(1'b1);
        idle(1'b1);
        check("drain_empty", 32'(exp_xfer.size()), 32'h0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
